// File: rtl/lc3_kbd_feeder.sv
// lc3_kbd_feeder: host byte FIFO feeding lc3_top keyboard pads one char at a time.
// Ports: clk, rst, host_vld/host_data/host_rdy stream in, flush, pad_kbsr in,
//        pad_kbdr/pad_in_dsr pads out, fifo_cnt occupancy, busy (FSM not IDLE).
module lc3_kbd_feeder #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             host_vld,
    input  logic [7:0]       host_data,
    output logic             host_rdy,
    input  logic             flush,
    input  logic [15:0]      pad_kbsr,
    output logic [15:0]      pad_kbdr,
    output logic [15:0]      pad_in_dsr,
    output logic [CNT_W-1:0] fifo_cnt,
    output logic             busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESENT,
        S_ACK,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]      char_q, char_d;
    logic            present_q, present_d;
    logic            push;
    logic            pop;
    logic            kbsr_rdy;
    logic            unused_kbsr;

    assign kbsr_rdy    = pad_kbsr[15];
    assign unused_kbsr = ^pad_kbsr[14:0];

    // Ready depends only on current occupancy; a same-cycle pop does not help.
    assign host_rdy = (cnt_q < FULL);
    assign push     = host_vld && host_rdy && !flush;
    assign pop      = (state_q == S_IDLE) && (cnt_q != '0) && !flush;

    assign pad_kbdr   = {8'h00, char_q};
    assign pad_in_dsr = {present_q, 15'b0};
    assign fifo_cnt   = cnt_q;
    assign busy       = (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        char_d    = char_q;
        present_d = present_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    char_d    = mem_q[rd_ptr_q];
                    present_d = 1'b1;
                    state_d   = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (kbsr_rdy) state_d = S_ACK;
            end
            S_ACK: begin
                // Keep the old char on pad_kbdr; only the ready flag drops.
                if (!kbsr_rdy) begin
                    present_d = 1'b0;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        if (flush) begin
            state_d   = S_IDLE;
            char_d    = 8'h00;
            present_d = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            char_q    <= 8'h00;
            present_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            char_q    <= char_d;
            present_q <= present_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= host_data;
    end

endmodule

// File: tb/tb_lc3_kbd_feeder.sv
// tb_lc3_kbd_feeder: self-checking bench for lc3_kbd_feeder.
// Vector table for single-char flows, scoreboard queue for ordered streams.
module tb_lc3_kbd_feeder;

    logic        clk;
    logic        rst;
    logic        host_vld;
    logic [7:0]  host_data;
    logic        host_rdy;
    logic        flush;
    logic [15:0] pad_kbsr;
    logic [15:0] pad_kbdr;
    logic [15:0] pad_in_dsr;
    logic [3:0]  fifo_cnt;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int maxc  = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0]  data;
        int          hold;
        logic [15:0] exp_kbdr;
        logic [15:0] exp_dsr;
    } vec_t;

    vec_t vt[4];

    lc3_kbd_feeder #(.FIFO_DEPTH(8), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .host_vld(host_vld),
        .host_data(host_data),
        .host_rdy(host_rdy),
        .flush(flush),
        .pad_kbsr(pad_kbsr),
        .pad_kbdr(pad_kbdr),
        .pad_in_dsr(pad_in_dsr),
        .fifo_cnt(fifo_cnt),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (int'(fifo_cnt) > maxc) maxc = int'(fifo_cnt);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one byte; queue it for the scoreboard when the DUT accepts it.
    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        host_vld  = 1'b1;
        host_data = b;
        while (!host_rdy && n < 50) begin
            tick();
            n++;
        end
        if (!host_rdy) chk("push_timeout", 32'(host_rdy), 32'd1);
        else sb.push_back(b);
        tick();
        host_vld = 1'b0;
    endtask

    // Wait for a presented char, compare with scoreboard, run handshake.
    task automatic consume_one(input int hold);
        int n;
        logic [7:0] e;
        n = 0;
        while (!pad_in_dsr[15] && n < 20) begin
            tick();
            n++;
        end
        if (!pad_in_dsr[15]) begin
            chk("present_timeout", 32'(pad_in_dsr), 32'h8000);
        end else begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'(sb.size()), 32'd1);
                e = 8'h00;
            end else begin
                e = sb.pop_front();
            end
            chk("sb_data", 32'(pad_kbdr), {24'h0, e});
            pad_kbsr = 16'h8000;
            repeat (hold) tick();
            pad_kbsr = 16'h0000;
            tick();
            chk("gap_dsr", 32'(pad_in_dsr), 32'h0);
            tick();
        end
    endtask

    initial begin
        logic [15:0] k0;
        int stable;

        vt[0] = '{8'h41, 1, 16'h0041, 16'h8000};
        vt[1] = '{8'h7A, 3, 16'h007A, 16'h8000};
        vt[2] = '{8'h00, 2, 16'h0000, 16'h8000};
        vt[3] = '{8'hFF, 1, 16'h00FF, 16'h8000};

        rst       = 1'b1;
        host_vld  = 1'b0;
        host_data = 8'h00;
        flush     = 1'b0;
        pad_kbsr  = 16'h0000;
        #13;
        rst = 1'b0;
        tick();

        chk("rst_kbdr", 32'(pad_kbdr), 32'h0);
        chk("rst_dsr", 32'(pad_in_dsr), 32'h0);
        chk("rst_cnt", 32'(fifo_cnt), 32'h0);
        chk("rst_rdy", 32'(host_rdy), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);

        for (int i = 0; i < 4; i++) begin
            host_vld  = 1'b1;
            host_data = vt[i].data;
            tick();
            host_vld = 1'b0;
            chk("vec_cnt1", 32'(fifo_cnt), 32'd1);
            chk("vec_dsr_n", 32'(pad_in_dsr), 32'h0);
            tick();
            chk("vec_kbdr", 32'(pad_kbdr), 32'(vt[i].exp_kbdr));
            chk("vec_dsr", 32'(pad_in_dsr), 32'(vt[i].exp_dsr));
            chk("vec_busy", 32'(busy), 32'h1);
            chk("vec_cnt0", 32'(fifo_cnt), 32'h0);
            pad_kbsr = 16'h8000;
            repeat (vt[i].hold) tick();
            chk("vec_ack_dsr", 32'(pad_in_dsr), 32'h8000);
            pad_kbsr = 16'h0000;
            tick();
            chk("vec_gap_dsr", 32'(pad_in_dsr), 32'h0);
            chk("vec_gap_kbdr", 32'(pad_kbdr), 32'(vt[i].exp_kbdr));
            tick();
            chk("vec_idle_busy", 32'(busy), 32'h0);
            chk("vec_idle_cnt", 32'(fifo_cnt), 32'h0);
        end

        maxc = 0;
        push_byte(8'h48);
        push_byte(8'h45);
        push_byte(8'h4C);
        push_byte(8'h4C);
        push_byte(8'h4F);
        repeat (5) consume_one(1);
        for (int i = 0; i < 8; i++) push_byte(8'h61 + 8'(i));
        repeat (8) consume_one(2);
        chk("wrap_sb_left", 32'(sb.size()), 32'd0);
        chk("wrap_max_le8", 32'(maxc <= 8), 32'd1);

        for (int i = 0; i < 8; i++) push_byte(8'h30 + 8'(i));
        chk("full_cnt7", 32'(fifo_cnt), 32'd7);
        chk("full_head", 32'(pad_kbdr), 32'h30);
        push_byte(8'h38);
        chk("full_cnt8", 32'(fifo_cnt), 32'd8);
        chk("full_rdy0", 32'(host_rdy), 32'd0);
        host_vld  = 1'b1;
        host_data = 8'h99;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("held_cnt", 32'(fifo_cnt), 32'd8);
            chk("held_rdy", 32'(host_rdy), 32'd0);
        end
        host_vld = 1'b0;
        repeat (9) consume_one(1);
        push_byte(8'h99);
        consume_one(1);
        chk("full_sb_left", 32'(sb.size()), 32'd0);

        push_byte(8'h50);
        push_byte(8'h51);
        chk("hold_cnt1", 32'(fifo_cnt), 32'd1);
        k0 = pad_kbdr;
        chk("hold_first", 32'(k0), 32'h50);
        void'(sb.pop_front());
        stable = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (pad_kbdr !== k0 || pad_in_dsr !== 16'h8000) stable = 0;
        end
        chk("hold_stable", 32'(stable), 32'd1);
        pad_kbsr = 16'h8000;
        repeat (3) tick();
        pad_kbsr = 16'h0000;
        tick();
        chk("hold_gap0", 32'(pad_in_dsr), 32'h0);
        tick();
        chk("hold_gap1", 32'(pad_in_dsr), 32'h0);
        chk("hold_cnt_still1", 32'(fifo_cnt), 32'd1);
        tick();
        chk("hold_next_dsr", 32'(pad_in_dsr), 32'h8000);
        consume_one(1);
        chk("hold_cnt0", 32'(fifo_cnt), 32'd0);

        push_byte(8'h58);
        push_byte(8'h59);
        push_byte(8'h5B);
        chk("fl_cnt2", 32'(fifo_cnt), 32'd2);
        chk("fl_dsr_pre", 32'(pad_in_dsr), 32'h8000);
        flush     = 1'b1;
        host_vld  = 1'b1;
        host_data = 8'h5A;
        tick();
        flush    = 1'b0;
        host_vld = 1'b0;
        sb.delete();
        chk("fl_cnt", 32'(fifo_cnt), 32'd0);
        chk("fl_dsr", 32'(pad_in_dsr), 32'h0);
        chk("fl_kbdr", 32'(pad_kbdr), 32'h0);
        chk("fl_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("fl_no5a_dsr", 32'(pad_in_dsr), 32'h0);
        chk("fl_no5a_cnt", 32'(fifo_cnt), 32'd0);

        push_byte(8'h41);
        tick();
        chk("ar_kbdr_pre", 32'(pad_kbdr), 32'h41);
        chk("ar_dsr_pre", 32'(pad_in_dsr), 32'h8000);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_kbdr", 32'(pad_kbdr), 32'h0);
        chk("ar_dsr", 32'(pad_in_dsr), 32'h0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_cnt", 32'(fifo_cnt), 32'd0);
        tick();
        rst = 1'b0;
        sb.delete();
        tick();
        chk("ar_rdy", 32'(host_rdy), 32'd1);
        chk("ar_dsr_after", 32'(pad_in_dsr), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
